// File: rtl/bp_me_mem_arbiter.sv
// Memory-side arbiter: merges per-CCE command channels onto one memory port and
// routes in-order responses back by tag FIFO. Option: BP_ME_MEM_ARB_FIXED_PRIO_EN.
module bp_me_mem_arbiter #(
  parameter int unsigned num_cce_p         = 2,
  parameter int unsigned cmd_width_p       = 96,
  parameter int unsigned resp_width_p      = 576,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [num_cce_p-1:0][cmd_width_p-1:0]      mem_cmd_i,
  input  logic [num_cce_p-1:0]                       mem_cmd_v_i,
  output logic [num_cce_p-1:0]                       mem_cmd_yumi_o,
  output logic [cmd_width_p-1:0]                     mem_cmd_o,
  output logic                                       mem_cmd_v_o,
  input  logic                                       mem_cmd_ready_i,
  input  logic [resp_width_p-1:0]                    mem_resp_i,
  input  logic                                       mem_resp_v_i,
  output logic                                       mem_resp_ready_o,
  output logic [num_cce_p-1:0][resp_width_p-1:0]     mem_resp_o,
  output logic [num_cce_p-1:0]                       mem_resp_v_o,
  input  logic [num_cce_p-1:0]                       mem_resp_ready_i,
  output logic [$clog2(max_outstanding_p+1)-1:0]     outstanding_o,
  output logic                                       resp_err_o
);

  localparam int unsigned id_w  = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;
  localparam int unsigned ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);

  logic [id_w-1:0]  rr_ptr_r;
  logic [id_w-1:0]  winner;
  logic             found;
  logic             load;
  logic             pop;
  logic             empty;
  logic [id_w-1:0]  head;
  logic [ptr_w-1:0] wr_ptr_r;
  logic [ptr_w-1:0] rd_ptr_r;
  logic [id_w-1:0]  tag_mem [max_outstanding_p];

  // Round-robin search starting at rr_ptr_r (pointer is constant 0 in fixed-priority mode)
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < num_cce_p; k++) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= num_cce_p) idx = idx - num_cce_p;
      if (!found && mem_cmd_v_i[idx]) begin
        found  = 1'b1;
        winner = id_w'(idx);
      end
    end
  end

  assign empty = (outstanding_o == '0);
  assign load  = (!mem_cmd_v_o || mem_cmd_ready_i)
              && (outstanding_o < cnt_w'(max_outstanding_p))
              && found && !reset_i;

  always_comb begin
    mem_cmd_yumi_o = '0;
    if (load) mem_cmd_yumi_o[winner] = 1'b1;
  end

  // Response routing to the CCE at the head of the tag FIFO
  assign head             = tag_mem[rd_ptr_r];
  assign mem_resp_ready_o = !empty && mem_resp_ready_i[head] && !reset_i;
  assign pop              = mem_resp_v_i && mem_resp_ready_o;

  always_comb begin
    mem_resp_v_o = '0;
    if (mem_resp_v_i && !empty && !reset_i) mem_resp_v_o[head] = 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < num_cce_p; i++) mem_resp_o[i] = mem_resp_i;
  end

`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
  assign rr_ptr_r = '0;
`else
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r <= '0;
    end else if (load) begin
      rr_ptr_r <= (winner == id_w'(num_cce_p - 1)) ? '0 : winner + id_w'(1);
    end
  end
`endif

  // Tag storage needs no reset: entries are only read while occupied
  always_ff @(posedge clk_i) begin
    if (load) tag_mem[wr_ptr_r] <= winner;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_cmd_o     <= '0;
      mem_cmd_v_o   <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      outstanding_o <= '0;
      resp_err_o    <= 1'b0;
    end else begin
      if (load) begin
        mem_cmd_o   <= mem_cmd_i[winner];
        mem_cmd_v_o <= 1'b1;
        wr_ptr_r    <= (wr_ptr_r == ptr_w'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + ptr_w'(1);
      end else if (mem_cmd_v_o && mem_cmd_ready_i) begin
        mem_cmd_v_o <= 1'b0;
      end

      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == ptr_w'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + ptr_w'(1);
      end

      case ({load, pop})
        2'b10:   outstanding_o <= outstanding_o + cnt_w'(1);
        2'b01:   outstanding_o <= outstanding_o - cnt_w'(1);
        default: outstanding_o <= outstanding_o;
      endcase

      if (mem_resp_v_i && empty) resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
// Directed self-checking bench for bp_me_mem_arbiter (2 CCEs, 4 outstanding).
module tb_bp_me_mem_arbiter;

  localparam int unsigned num_cce_p         = 2;
  localparam int unsigned cmd_width_p       = 96;
  localparam int unsigned resp_width_p      = 576;
  localparam int unsigned max_outstanding_p = 4;

  logic                                    clk_i;
  logic                                    reset_i;
  logic [num_cce_p-1:0][cmd_width_p-1:0]   mem_cmd_i;
  logic [num_cce_p-1:0]                    mem_cmd_v_i;
  logic [num_cce_p-1:0]                    mem_cmd_yumi_o;
  logic [cmd_width_p-1:0]                  mem_cmd_o;
  logic                                    mem_cmd_v_o;
  logic                                    mem_cmd_ready_i;
  logic [resp_width_p-1:0]                 mem_resp_i;
  logic                                    mem_resp_v_i;
  logic                                    mem_resp_ready_o;
  logic [num_cce_p-1:0][resp_width_p-1:0]  mem_resp_o;
  logic [num_cce_p-1:0]                    mem_resp_v_o;
  logic [num_cce_p-1:0]                    mem_resp_ready_i;
  logic [2:0]                              outstanding_o;
  logic                                    resp_err_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0]  exp_grant [4];
  logic [95:0] exp_cmd   [4];

  bp_me_mem_arbiter #(
    .num_cce_p(num_cce_p), .cmd_width_p(cmd_width_p),
    .resp_width_p(resp_width_p), .max_outstanding_p(max_outstanding_p)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_yumi_o(mem_cmd_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
    exp_cmd[0] = 96'h100; exp_cmd[1] = 96'h100; exp_cmd[2] = 96'h100; exp_cmd[3] = 96'h100;
`else
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    exp_cmd[0] = 96'h100; exp_cmd[1] = 96'h200; exp_cmd[2] = 96'h100; exp_cmd[3] = 96'h200;
`endif
    reset_i          = 1'b1;
    mem_cmd_i        = '0;
    mem_cmd_v_i      = 2'b11;
    mem_cmd_ready_i  = 1'b1;
    mem_resp_i       = '0;
    mem_resp_v_i     = 1'b1;
    mem_resp_ready_i = 2'b11;

    // Reset: outputs forced low while reset is held
    tick();
    check("rst_yumi", 128'(mem_cmd_yumi_o), 128'h0);
    check("rst_resp_v", 128'(mem_resp_v_o), 128'h0);
    check("rst_resp_ready", 128'(mem_resp_ready_o), 128'h0);
    tick();
    check("rst_cmd_v", 128'(mem_cmd_v_o), 128'h0);
    check("rst_cmd", 128'(mem_cmd_o), 128'h0);
    check("rst_outstanding", 128'(outstanding_o), 128'h0);
    check("rst_err", 128'(resp_err_o), 128'h0);
    reset_i = 1'b0; mem_cmd_v_i = '0; mem_resp_v_i = 1'b0;

    // Single requester
    mem_cmd_i[0] = 96'hA5; mem_cmd_v_i = 2'b01;
    #1 check("single_yumi", 128'(mem_cmd_yumi_o), 128'h1);
    tick();
    mem_cmd_v_i = '0;
    check("single_cmd", 128'(mem_cmd_o), 128'hA5);
    check("single_cmd_v", 128'(mem_cmd_v_o), 128'h1);
    check("single_outstanding", 128'(outstanding_o), 128'h1);
    mem_resp_i = 576'h11; mem_resp_v_i = 1'b1; mem_resp_ready_i = 2'b11;
    #1 check("single_resp_v", 128'(mem_resp_v_o), 128'h1);
    check("single_resp_ready", 128'(mem_resp_ready_o), 128'h1);
    check("single_resp_data", 128'(mem_resp_o[1]), 128'h11);
    tick();
    mem_resp_v_i = 1'b0;
    check("single_drained_outstanding", 128'(outstanding_o), 128'h0);
    check("single_drained_v", 128'(mem_cmd_v_o), 128'h0);

    // Reset to bring the round-robin pointer back to 0
    reset_i = 1'b1; tick(); reset_i = 1'b0;

    // Contention with immediate responses
    mem_cmd_i[0] = 96'h100; mem_cmd_i[1] = 96'h200; mem_cmd_v_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      mem_resp_v_i = (k > 0);
      #1 check($sformatf("cont_grant%0d", k), 128'(mem_cmd_yumi_o), 128'(exp_grant[k]));
      tick();
      check($sformatf("cont_cmd%0d", k), 128'(mem_cmd_o), 128'(exp_cmd[k]));
      check($sformatf("cont_outstanding%0d", k), 128'(outstanding_o), 128'h1);
    end
    mem_cmd_v_i = '0; mem_resp_v_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0;
    check("cont_end_outstanding", 128'(outstanding_o), 128'h0);
    check("cont_end_v", 128'(mem_cmd_v_o), 128'h0);

    // Backpressure: load while not ready, hold 3 cycles, reload on first ready
    mem_cmd_ready_i = 1'b0; mem_cmd_i[0] = 96'hB1; mem_cmd_v_i = 2'b01;
    #1 check("bp_first_yumi", 128'(mem_cmd_yumi_o), 128'h1);
    tick();
    mem_cmd_i[0] = 96'hB2;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("bp_stall_yumi%0d", k), 128'(mem_cmd_yumi_o), 128'h0);
      tick();
      check($sformatf("bp_stall_cmd%0d", k), 128'(mem_cmd_o), 128'hB1);
    end
    mem_cmd_ready_i = 1'b1;
    #1 check("bp_reload_yumi", 128'(mem_cmd_yumi_o), 128'h1);
    tick();
    mem_cmd_v_i = '0;
    check("bp_reload_cmd", 128'(mem_cmd_o), 128'hB2);
    check("bp_reload_v", 128'(mem_cmd_v_o), 128'h1);
    check("bp_outstanding", 128'(outstanding_o), 128'h2);
    mem_resp_v_i = 1'b1;
    tick(); tick();
    mem_resp_v_i = 1'b0;
    check("bp_drain_outstanding", 128'(outstanding_o), 128'h0);

    // Credit full
    mem_cmd_i[0] = 96'hC0; mem_cmd_v_i = 2'b01;
    tick(); tick(); tick(); tick();
    check("full_outstanding", 128'(outstanding_o), 128'h4);
    #1 check("full_yumi", 128'(mem_cmd_yumi_o), 128'h0);
    tick();
    check("full_v_drained", 128'(mem_cmd_v_o), 128'h0);
    mem_resp_v_i = 1'b1;
    #1 check("full_pop_no_free", 128'(mem_cmd_yumi_o), 128'h0);
    tick();
    mem_resp_v_i = 1'b0;
    check("full_after_pop", 128'(outstanding_o), 128'h3);
    #1 check("full_credit_yumi", 128'(mem_cmd_yumi_o), 128'h1);
    tick();
    mem_cmd_v_i = '0;
    check("full_refill", 128'(outstanding_o), 128'h4);
    mem_resp_v_i = 1'b1;
    tick(); tick(); tick(); tick();
    mem_resp_v_i = 1'b0;
    check("full_drain", 128'(outstanding_o), 128'h0);

    // Ordering: CCE1, CCE0, CCE1
    mem_cmd_i[0] = 96'hD0; mem_cmd_i[1] = 96'hD1;
    mem_cmd_v_i = 2'b10; tick();
    mem_cmd_v_i = 2'b01; tick();
    mem_cmd_v_i = 2'b10; tick();
    mem_cmd_v_i = '0;
    check("ord_outstanding", 128'(outstanding_o), 128'h3);
    mem_resp_ready_i = 2'b10; mem_resp_v_i = 1'b1; mem_resp_i = 576'h51;
    #1 check("ord_r1_v", 128'(mem_resp_v_o), 128'h2);
    check("ord_r1_ready", 128'(mem_resp_ready_o), 128'h1);
    tick();
    mem_resp_i = 576'h52;
    #1 check("ord_r2_v", 128'(mem_resp_v_o), 128'h1);
    check("ord_r2_stall", 128'(mem_resp_ready_o), 128'h0);
    tick();
    check("ord_r2_held", 128'(outstanding_o), 128'h2);
    mem_resp_ready_i = 2'b11;
    #1 check("ord_r2_ready", 128'(mem_resp_ready_o), 128'h1);
    tick();
    mem_resp_ready_i = 2'b10; mem_resp_i = 576'h53;
    #1 check("ord_r3_v", 128'(mem_resp_v_o), 128'h2);
    check("ord_r3_data", 128'(mem_resp_o[0]), 128'h53);
    tick();
    mem_resp_v_i = 1'b0; mem_resp_ready_i = 2'b11;
    check("ord_done", 128'(outstanding_o), 128'h0);

    // Error: response with nothing outstanding
    mem_resp_v_i = 1'b1;
    #1 check("err_ready", 128'(mem_resp_ready_o), 128'h0);
    check("err_resp_v", 128'(mem_resp_v_o), 128'h0);
    tick();
    mem_resp_v_i = 1'b0;
    check("err_set", 128'(resp_err_o), 128'h1);
    tick();
    check("err_sticky", 128'(resp_err_o), 128'h1);

    // Reset mid-stream
    mem_cmd_ready_i = 1'b0; mem_cmd_i[0] = 96'hE0; mem_cmd_v_i = 2'b01;
    tick();
    check("mid_loaded", 128'(outstanding_o), 128'h1);
    reset_i = 1'b1;
    #1 check("mid_rst_yumi", 128'(mem_cmd_yumi_o), 128'h0);
    tick();
    reset_i = 1'b0; mem_cmd_v_i = '0;
    check("mid_cmd_v", 128'(mem_cmd_v_o), 128'h0);
    check("mid_cmd", 128'(mem_cmd_o), 128'h0);
    check("mid_outstanding", 128'(outstanding_o), 128'h0);
    check("mid_err", 128'(resp_err_o), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
